// File: rtl/arb4x32_pkg.sv
// Shared widths and mux select encodings for the arb4x32 arbiter slice.
package arb4x32_pkg;
  localparam int NCH  = 4;
  localparam int DW   = 32;
  localparam int SELW = 2;

  typedef enum logic [SELW-1:0] {
    SEL_A0 = 2'b00,
    SEL_A1 = 2'b01,
    SEL_A2 = 2'b10,
    SEL_A3 = 2'b11
  } sel_e;
endpackage

// File: rtl/arb4x32_mux.sv
// mux4x32: four-input 32-bit datapath mux, select s picks a0..a3.
module mux4x32
  import arb4x32_pkg::*;
(
  input  logic [DW-1:0]   a0,
  input  logic [DW-1:0]   a1,
  input  logic [DW-1:0]   a2,
  input  logic [DW-1:0]   a3,
  input  logic [SELW-1:0] s,
  output logic [DW-1:0]   y
);
  always_comb begin
    y = a0;
    unique case (sel_e'(s))
      SEL_A1:  y = a1;
      SEL_A2:  y = a2;
      SEL_A3:  y = a3;
      default: y = a0;
    endcase
  end
endmodule

// File: rtl/arb4x32.sv
// arb4x32: 4-channel round-robin arbiter feeding mux4x32 into a registered output stage.
// Define ARB4X32_LOCK_EN to add the per-channel `last` port and burst lock.
module arb4x32
  import arb4x32_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   a0,
  input  logic [DW-1:0]   a1,
  input  logic [DW-1:0]   a2,
  input  logic [DW-1:0]   a3,
  input  logic [NCH-1:0]  v,
  output logic [NCH-1:0]  r,
  output logic [SELW-1:0] s,
  output logic [DW-1:0]   y,
  output logic            yv,
  input  logic            yr
`ifdef ARB4X32_LOCK_EN
  ,
  input  logic [NCH-1:0]  last
`endif
);

  // Returns {found, index}; scanning downward lets the nearest offset from start win.
  function automatic logic [SELW:0] rr_scan(input logic [NCH-1:0] req,
                                            input logic [SELW-1:0] start);
    logic [SELW-1:0] idx;
    rr_scan = {1'b0, start};
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = start + SELW'(k);
      if (req[idx]) rr_scan = {1'b1, idx};
    end
  endfunction

  logic [SELW-1:0] ptr_q, ptr_d;
  logic [DW-1:0]   y_q, y_d;
  logic            yv_q, yv_d;
  logic [DW-1:0]   mux_y;
  logic [SELW:0]   scan;
  logic [SELW-1:0] gnt;
  logic            gnt_vld;
  logic            acc;
  logic            xfer;
`ifdef ARB4X32_LOCK_EN
  logic            locked_q, locked_d;
  logic [SELW-1:0] lch_q, lch_d;
`endif

  always_comb begin
    scan    = rr_scan(v, ptr_q);
    gnt     = scan[SELW-1:0];
    gnt_vld = scan[SELW];
`ifdef ARB4X32_LOCK_EN
    if (locked_q) begin
      gnt     = lch_q;
      gnt_vld = v[lch_q];
    end
`endif
    acc  = !yv_q || yr;
    xfer = !rst && acc && gnt_vld;
    r    = xfer ? (NCH'(1) << gnt) : '0;
    s    = gnt;
  end

  mux4x32 u_mux (
    .a0 (a0),
    .a1 (a1),
    .a2 (a2),
    .a3 (a3),
    .s  (s),
    .y  (mux_y)
  );

  always_comb begin
    y_d   = y_q;
    yv_d  = yv_q;
    ptr_d = ptr_q;
`ifdef ARB4X32_LOCK_EN
    locked_d = locked_q;
    lch_d    = lch_q;
`endif
    if (xfer) begin
      y_d   = mux_y;
      yv_d  = 1'b1;
      ptr_d = gnt + SELW'(1);
`ifdef ARB4X32_LOCK_EN
      // Mid-burst beats pin the grant and freeze the round-robin pointer.
      if (!last[gnt]) begin
        locked_d = 1'b1;
        lch_d    = gnt;
        ptr_d    = ptr_q;
      end else begin
        locked_d = 1'b0;
      end
`endif
    end else if (yr) begin
      yv_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q      <= '0;
      yv_q     <= 1'b0;
      ptr_q    <= '0;
`ifdef ARB4X32_LOCK_EN
      locked_q <= 1'b0;
      lch_q    <= '0;
`endif
    end else begin
      y_q      <= y_d;
      yv_q     <= yv_d;
      ptr_q    <= ptr_d;
`ifdef ARB4X32_LOCK_EN
      locked_q <= locked_d;
      lch_q    <= lch_d;
`endif
    end
  end

  assign y  = y_q;
  assign yv = yv_q;

endmodule

// File: tb/tb_arb4x32.sv
// Scoreboard bench for arb4x32: stimulus pushes expected words, a negedge monitor pops them.
module tb_arb4x32;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a0, a1, a2, a3;
  logic [3:0]  v;
  logic [3:0]  r;
  logic [1:0]  s;
  logic [31:0] y;
  logic        yv;
  logic        yr;
`ifdef ARB4X32_LOCK_EN
  logic [3:0]  last;
`endif

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  arb4x32 dut (
    .clk (clk), .rst (rst),
    .a0 (a0), .a1 (a1), .a2 (a2), .a3 (a3),
    .v (v), .r (r), .s (s), .y (y), .yv (yv), .yr (yr)
`ifdef ARB4X32_LOCK_EN
    , .last (last)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Caller drives inputs just after posedge; this checks r/s (and optionally y/yv) at negedge.
  task automatic cyc(input string nm, input logic [3:0] er, input logic [1:0] es,
                     input bit push, input logic [31:0] d,
                     input bit cy, input logic [31:0] ey, input logic eyv);
    if (push) exp_q.push_back(d);
    @(negedge clk);
    chk({nm, " r"}, 32'(r), 32'(er));
    chk({nm, " s"}, 32'(s), 32'(es));
    if (cy) begin
      chk({nm, " y"}, y, ey);
      chk({nm, " yv"}, 32'(yv), 32'(eyv));
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (yv === 1'b1 && yr === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected output: got %h expected none", y);
      end else begin
        chk("scoreboard y", y, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; v = 4'b1111; yr = 1'b1;
    a0 = 32'h0000_00A0; a1 = 32'h0000_00A1; a2 = 32'h0000_00A2; a3 = 32'h0000_00A3;
`ifdef ARB4X32_LOCK_EN
    last = 4'b1111;
`endif
    @(posedge clk); #1;
    cyc("rst0", 4'b0000, 2'd0, 0, 0, 1, 32'h0, 1'b0);
    cyc("rst1", 4'b0000, 2'd0, 0, 0, 1, 32'h0, 1'b0);
    rst = 1'b0;
    cyc("rr0", 4'b0001, 2'd0, 1, 32'h0000_00A0, 1, 32'h0, 1'b0);
    cyc("rr1", 4'b0010, 2'd1, 1, 32'h0000_00A1, 1, 32'h0000_00A0, 1'b1);
    cyc("rr2", 4'b0100, 2'd2, 1, 32'h0000_00A2, 1, 32'h0000_00A1, 1'b1);
    cyc("rr3", 4'b1000, 2'd3, 1, 32'h0000_00A3, 1, 32'h0000_00A2, 1'b1);
    cyc("rr4", 4'b0001, 2'd0, 1, 32'h0000_00A0, 1, 32'h0000_00A3, 1'b1);

    v = 4'b0100; a2 = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++)
      cyc("single", 4'b0100, 2'd2, 1, 32'hDEAD_BEEF, 0, 0, 1'b0);

    v = 4'b1111; a2 = 32'h0000_00A2; yr = 1'b0;
    for (int i = 0; i < 3; i++)
      cyc("bp", 4'b0000, 2'd3, 0, 0, 1, 32'hDEAD_BEEF, 1'b1);
    yr = 1'b1;
    cyc("bp_rel", 4'b1000, 2'd3, 1, 32'h0000_00A3, 1, 32'hDEAD_BEEF, 1'b1);

    v = 4'b0000;
    cyc("idle0", 4'b0000, 2'd0, 0, 0, 1, 32'h0000_00A3, 1'b1);
    cyc("idle1", 4'b0000, 2'd0, 0, 0, 1, 32'h0000_00A3, 1'b0);

`ifdef ARB4X32_LOCK_EN
    v = 4'b0001; last = 4'b0001;
    cyc("lk_ch0", 4'b0001, 2'd0, 1, 32'h0000_00A0, 0, 0, 1'b0);
    v = 4'b0111; last = 4'b0000; a1 = 32'h0000_00B0;
    cyc("lk_b0", 4'b0010, 2'd1, 1, 32'h0000_00B0, 0, 0, 1'b0);
    a1 = 32'h0000_00B1;
    cyc("lk_b1", 4'b0010, 2'd1, 1, 32'h0000_00B1, 0, 0, 1'b0);
    a1 = 32'h0000_00B2; last = 4'b0010;
    cyc("lk_b2", 4'b0010, 2'd1, 1, 32'h0000_00B2, 0, 0, 1'b0);
    last = 4'b0100;
    cyc("lk_next", 4'b0100, 2'd2, 1, 32'h0000_00A2, 0, 0, 1'b0);
    v = 4'b1000; last = 4'b0000; a3 = 32'h0000_00C0;
    cyc("lk3_b0", 4'b1000, 2'd3, 1, 32'h0000_00C0, 0, 0, 1'b0);
    a3 = 32'h0000_00C1;
    cyc("lk3_b1", 4'b1000, 2'd3, 1, 32'h0000_00C1, 0, 0, 1'b0);
    rst = 1'b1;
    cyc("lk_rst0", 4'b0000, 2'd3, 0, 0, 1, 32'h0000_00C1, 1'b1);
    cyc("lk_rst1", 4'b0000, 2'd3, 0, 0, 1, 32'h0, 1'b0);
    rst = 1'b0; v = 4'b1001; last = 4'b0001;
    cyc("lk_post", 4'b0001, 2'd0, 1, 32'h0000_00A0, 0, 0, 1'b0);
`else
    v = 4'b1010;
    cyc("sparse0", 4'b0010, 2'd1, 1, 32'h0000_00A1, 0, 0, 1'b0);
    cyc("sparse1", 4'b1000, 2'd3, 1, 32'h0000_00A3, 0, 0, 1'b0);
    cyc("sparse2", 4'b0010, 2'd1, 1, 32'h0000_00A1, 0, 0, 1'b0);
    rst = 1'b1;
    cyc("mid_rst0", 4'b0000, 2'd3, 0, 0, 1, 32'h0000_00A1, 1'b1);
    cyc("mid_rst1", 4'b0000, 2'd1, 0, 0, 1, 32'h0, 1'b0);
    rst = 1'b0; v = 4'b1001;
    cyc("post_rst", 4'b0001, 2'd0, 1, 32'h0000_00A0, 0, 0, 1'b0);
`endif

    v = 4'b0000;
    for (int i = 0; i < 3; i++)
      cyc("drain", 4'b0000, 2'd1, 0, 0, 0, 0, 1'b0);
    chk("scoreboard empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/arb4x32.md
# arb4x32

Four-channel 32-bit round-robin arbiter that sits directly upstream of the `mux4x32` datapath mux. It takes valid/ready requests from four 32-bit sources and drives the mux select `s` with the granted channel. It registers the mux output `y` into a single-stage output register with its own valid/ready handshake. It converts four independent producers into one ordered 32-bit stream at up to one word per cycle.

## Interface
Parameters: none; widths are fixed at 4 channels × 32 bits.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset; synchronous, active-high
- `a0`, `a1`, `a2`, `a3`  in  32 each  channel data
- `v`  in  4  per-channel valid; bit i belongs to `ai`
- `r`  out  4  per-channel ready; one-hot or zero; combinational
- `s`  out  2  select to mux; current grant index; combinational
- `y`  out  32  registered output data
- `yv`  out  1  output valid; registered
- `yr`  in  1  downstream ready
- `last`  in  4  per-channel end-of-burst; present only with `ARB4X32_LOCK_EN`

## Operation
- State:
  - `ptr[1:0]`: round-robin start point.
  - Output register `y`/`yv`.
  - With the macro only: `locked` and `lch[1:0]`.
- Accept condition: `acc = !yv || yr`.
- Grant:
  - The grant is the first index i with `v[i]=1`, scanning `ptr, ptr+1, ptr+2, ptr+3` mod 4.
  - If no `v` bit is set, `s = ptr` and no grant is made.
- Handshake:
  - `r[g] = acc && v[g]` for the grant index g; every other bit of `r` is 0.
  - A beat transfers on channel g when `v[g] && r[g]`.
- On a transfer:
  - `y <= mux4x32(a0..a3, s)`.
  - `yv <= 1`.
  - `ptr <= g+1`; 3 wraps to 0.
- On `acc` with no valid input: `yv <= 0` when `yr=1`; `y` holds its value.
- On `yv && !yr`: `y`, `yv` and `ptr` hold; `r = 0`.
- Reset values: `y=0`, `yv=0`, `ptr=0`, `locked=0`, `lch=0`. Outputs derived from these: `r=0` during reset; `s=0` after reset with no valid input.
- While `rst=1`:
  - `r` is forced to 0.
  - No beat transfers.
  - Reset takes priority over every simultaneous event.

## Timing
- Latency: one cycle from input transfer to `yv=1` with the data on `y`.
- Throughput: one word per cycle while `yr=1`.
- Fairness: with all four channels continuously valid, grants are strictly 0,1,2,3,0,… after reset. No channel waits more than 3 transfers.
- Combinational paths:
  - `v` and `yr` feed into `r` and `s`.
  - `s` feeds the mux, and the mux feeds the `y` register input.
  - No path from `yr` to `yv` or `y` within the same cycle.
- A change in `v` while `r=0` is legal. A source may drop `v` before it is granted.

## Configuration
- Macro: `ARB4X32_LOCK_EN`.
- Defined: burst lock is enabled and the `last` port exists.
  - A transfer from channel g with `last[g]=0` sets `locked=1` and `lch=g`.
  - While `locked=1`, the grant is forced to `lch`. Other channels get `r=0` even if valid.
  - `ptr` does not advance during the burst.
  - A transfer with `last[lch]=1` clears `locked` and sets `ptr <= lch+1`.
  - If `v[lch]=0` while locked, there is no transfer and the lock is kept.
- Not defined:
  - The `last` port is absent and there is no lock state.
  - Every beat is a single-beat burst, with re-arbitration each cycle.

## Structure
- Shared package: `NCH=4`, `DW=32`, `SELW=2`, and select encodings `SEL_A0..SEL_A3 = 2'b00..2'b11`.
- Sub-module: instantiate the existing `mux4x32` for the datapath, driven by `s`. The arbiter logic (priority scan, pointer, lock) stays in this module. The priority scan may be a function in the same file.

## Test plan
- Reset: `rst=1` for 2 cycles with `v=4'b1111`, `yr=1`.
  - During reset: `r=0`, `yv=0`, `y=0`.
  - First cycle after reset: `r=4'b0001`, `s=0`.
- Round-robin: `a0..a3` = `32'h0000_00A0`, `32'h0000_00A1`, `32'h0000_00A2`, `32'h0000_00A3`; `v=4'b1111`; `yr=1`.
  - `y` = A0, A1, A2, A3, A0 on consecutive cycles, with `yv=1` throughout.
- Single source: `v=4'b0100`, `a2=32'hDEAD_BEEF`, `yr=1`.
  - Channel 2 is granted every cycle; `y=32'hDEAD_BEEF` back-to-back.
- Backpressure: hold `yr=0` for 3 cycles while `yv=1` and `v=4'b1111`.
  - `y` and `ptr` are stable and `r=0`.
  - When `yr` returns to 1, the next grant is the held `ptr` channel.
- Lock (macro on): channel 1 sends 3 beats with `last` = 0, 0, 1 while `v=4'b0111`.
  - Grants are 1, 1, 1, then 2. Channels 0 and 2 see `r=0` during the burst.
- Reset mid-burst (macro on): assert `rst` after the second beat of a channel-3 burst.
  - `locked=0`, `ptr=0`, `yv=0`.
  - After release with `v=4'b1001`, channel 0 is granted first.
